rr_dispatcher: RTL



---
 rtl/rr_dispatcher_pkg.sv | 18 +
 rtl/rr_dispatcher_ff_pick.sv | 26 ++
 rtl/rr_dispatcher.sv | 108 ++++++++++
 3 files changed

// File: rtl/rr_dispatcher_pkg.sv
// Shared types and defaults for the round-robin lane dispatcher.
// Lane count follows the systolic array width.
`ifndef SA_NUM
`define SA_NUM 4
`endif

package rr_dispatcher_pkg;

  typedef enum logic [0:0] {
    PICK  = 1'b0,
    BURST = 1'b1
  } disp_state_t;

  localparam int DISP_NUM_DST   = `SA_NUM;
  localparam int DISP_BURST_LEN = 1;
  localparam int DISP_DATA_W    = 32;

endpackage

// File: rtl/rr_dispatcher_ff_pick.sv
// Combinational find-first-set: lowest set request wins.
// Returns one-hot grant, binary index and an any flag.
module rr_dispatcher_ff_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin scatter of one valid/ready stream onto lane FIFOs.
// Bursts of BURST_LEN beats per lane; full lanes skipped at pick time.
module rr_dispatcher
  import rr_dispatcher_pkg::*;
#(
  parameter int NUM_DST   = DISP_NUM_DST,
  parameter int DATA_W    = DISP_DATA_W,
  parameter int BURST_LEN = DISP_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NUM_DST-1:0] full,
  output logic [NUM_DST-1:0] wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [31:0]       beat_cnt
);

  localparam int IW = $clog2(NUM_DST);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  disp_state_t        state;
  logic [NUM_DST-1:0] mask_ff;
  logic [IW-1:0]      cur_ff;
  logic [CW-1:0]      burst_cnt;

  logic [NUM_DST-1:0] avail;
  logic [NUM_DST-1:0] m_gnt, u_gnt;
  logic [IW-1:0]      m_idx, u_idx;
  logic               m_any, u_any;
  logic [IW-1:0]      pick_idx;
  logic [NUM_DST-1:0] sel;
  logic [NUM_DST-1:0] mask_nxt;
  logic               hs;

  assign avail = ~full;

  rr_dispatcher_ff_pick #(.N(NUM_DST)) u_mpick (
    .req (avail & mask_ff),
    .gnt (m_gnt),
    .idx (m_idx),
    .any (m_any)
  );

  rr_dispatcher_ff_pick #(.N(NUM_DST)) u_upick (
    .req (avail),
    .gnt (u_gnt),
    .idx (u_idx),
    .any (u_any)
  );

  assign pick_idx = m_any ? m_idx : u_idx;

  always_comb begin
    sel      = '0;
    in_ready = 1'b0;
    if (state == BURST) begin
      sel[cur_ff] = 1'b1;
      in_ready    = disp_en & ~full[cur_ff];
    end else begin
      sel      = m_any ? m_gnt : u_gnt;
      in_ready = disp_en & u_any;
    end
    if (rst) in_ready = 1'b0;
  end

  // Next-pick mask keeps only lanes above the one just served.
  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < NUM_DST; i++)
      mask_nxt[i] = IW'(i) > pick_idx;
  end

  assign hs      = in_valid & in_ready;
  assign wr_en   = {NUM_DST{hs}} & sel;
  assign wr_data = in_data;
  assign busy    = ~rst & (state == BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PICK;
      mask_ff   <= '1;
      cur_ff    <= '0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (state == PICK) begin
        cur_ff  <= pick_idx;
        mask_ff <= mask_nxt;
        if (BURST_LEN > 1) begin
          state     <= BURST;
          burst_cnt <= CW'(1);
        end
      end else if (burst_cnt == CW'(BURST_LEN - 1)) begin
        state     <= PICK;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + CW'(1);
      end
    end
  end

endmodule
